// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary-to-BCD converter and its client.
// The client drives the start request and value; the converter returns busy/done and the digit bus.
interface bin2bcd_seq_if #(
    parameter int BIN_W = 20
);
    logic             iSTART;
    logic [BIN_W-1:0] iBIN;
    logic             oBUSY;
    logic             oDONE;
    logic             oOVF;
    logic [31:0]      oDIG;

    modport master (
        output iSTART, iBIN,
        input  oBUSY, oDONE, oOVF, oDIG
    );

    modport slave (
        input  iSTART, iBIN,
        output oBUSY, oDONE, oOVF, oDIG
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per input bit, start/done handshake,
// saturating packed-BCD result for a seven-segment digit bus.
//
// state | meaning
// IDLE  | waiting for iSTART; result outputs hold the last value
// SHIFT | add-3 then shift {scr, shReg}, one iteration per input bit
// DONE  | scratch holds the final BCD; publish it, optionally re-latch
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input logic          iCLK,
    input logic          iRST_N,
    bin2bcd_seq_if.slave bus
);
    // ceil(BIN_W*log10(2)) digits so the scratch register never truncates
    localparam int SCR_CALC = (BIN_W * 30103 + 99999) / 100000;
    localparam int SCR_D    = (SCR_CALC > DIGITS) ? SCR_CALC : DIGITS;
    localparam int SCR_W    = 4 * SCR_D;
    localparam int CNT_W    = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateE;

    stateE            state;
    logic [BIN_W-1:0] shReg;
    logic [SCR_W-1:0] scr;
    logic [SCR_W-1:0] scrAdj;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      digNext;
    logic             ovfNext;

    always_comb begin
        scrAdj = scr;
        for (int k = 0; k < SCR_D; k++) begin
            if (scr[4*k +: 4] >= 4'd5) scrAdj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
        end
    end

    // Digits above the display width signal overflow; the display then saturates to all 9s.
    always_comb begin
        digNext = '0;
        ovfNext = 1'b0;
        for (int k = 0; k < SCR_D; k++) begin
            if (k < DIGITS) digNext[4*k +: 4] = scr[4*k +: 4];
            else if (scr[4*k +: 4] != 4'd0) ovfNext = 1'b1;
        end
        if (ovfNext) begin
            for (int k = 0; k < DIGITS; k++) digNext[4*k +: 4] = 4'h9;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            shReg     <= '0;
            scr       <= '0;
            cnt       <= '0;
            bus.oBUSY <= 1'b0;
            bus.oDONE <= 1'b0;
            bus.oOVF  <= 1'b0;
            bus.oDIG  <= '0;
        end else begin
            bus.oBUSY <= (state == SHIFT);
            bus.oDONE <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        shReg <= bus.iBIN;
                        scr   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scr, shReg} <= {scrAdj, shReg} << 1;
                    cnt          <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    bus.oDIG <= digNext;
                    bus.oOVF <= ovfNext;
                    if (bus.iSTART) begin
                        shReg <= bus.iBIN;
                        scr   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: expected results are queued at each start
// and compared against the digit bus when oDONE pulses.
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [32:0] sb[$];

    bin2bcd_seq_if #(.BIN_W(20)) bus ();

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, packed BCD} for a six-digit display
    function automatic logic [32:0] model(input int v);
        logic [32:0] r;
        int t;
        r = '0;
        if (v > 999999) begin
            r = {1'b1, 32'h00999999};
        end else begin
            t = v;
            for (int k = 0; k < 6; k++) begin
                r[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    // One-cycle start pulse; returns at the negedge after the accepting posedge.
    task automatic start_conv(input int v);
        @(negedge clk);
        bus.iBIN   = 20'(v);
        bus.iSTART = 1'b1;
        sb.push_back(model(v));
        @(negedge clk);
        bus.iSTART = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.iSTART = 1'b0;
        bus.iBIN   = '0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.oDIG !== 32'h0 || bus.oOVF !== 1'b0) begin
            bad++;
            $display("FAIL reset_result dig=%h ovf=%b want dig=00000000 ovf=0", bus.oDIG, bus.oOVF);
        end
        total++;
        if (bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.oBUSY, bus.oDONE);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero();
        int busyCnt, doneCnt, doneAt;
        logic [32:0] exp;
        busyCnt = 0; doneCnt = 0; doneAt = 0;
        start_conv(0);
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.oBUSY === 1'b1) busyCnt++;
            if (bus.oDONE === 1'b1) begin
                doneCnt++;
                doneAt = i;
                exp = sb.pop_front();
                total++;
                if (bus.oDIG !== exp[31:0] || bus.oOVF !== exp[32]) begin
                    bad++;
                    $display("FAIL zero_result dig=%h ovf=%b want dig=%h ovf=%b", bus.oDIG, bus.oOVF, exp[31:0], exp[32]);
                end
            end
        end
        total++;
        if (doneAt != 22 || doneCnt != 1) begin
            bad++;
            $display("FAIL zero_latency done_at=%0d done_cnt=%0d want 22 1", doneAt, doneCnt);
        end
        total++;
        if (busyCnt != 20) begin
            bad++;
            $display("FAIL zero_busy busy_cycles=%0d want 20", busyCnt);
        end
    endtask

    task automatic test_values(input string name, input int v0, input int v1, input int v2);
        int vals[3];
        int c;
        logic [32:0] exp;
        vals = '{v0, v1, v2};
        foreach (vals[j]) begin
            start_conv(vals[j]);
            c = 1;
            while (bus.oDONE !== 1'b1 && c < 40) begin
                @(negedge clk);
                c++;
            end
            exp = sb.pop_front();
            total++;
            if (bus.oDONE !== 1'b1) begin
                bad++;
                $display("FAIL %s_timeout v=%0d no done within %0d cycles", name, vals[j], c);
            end else if (bus.oDIG !== exp[31:0] || bus.oOVF !== exp[32] || c != 22) begin
                bad++;
                $display("FAIL %s_result v=%0d dig=%h ovf=%b at=%0d want dig=%h ovf=%b at=22",
                         name, vals[j], bus.oDIG, bus.oOVF, c, exp[31:0], exp[32]);
            end
            @(negedge clk);
            total++;
            if (bus.oDONE !== 1'b0 || bus.oDIG !== exp[31:0]) begin
                bad++;
                $display("FAIL %s_pulse v=%0d done=%b dig=%h want done=0 dig=%h", name, vals[j], bus.oDONE, bus.oDIG, exp[31:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int c, glitches, extra;
        logic [31:0] digBefore;
        logic [32:0] exp;
        glitches = 0; extra = 0;
        digBefore = bus.oDIG;
        start_conv(555555);
        c = 1;
        while (bus.oDONE !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 5) begin
                bus.iSTART = 1'b1;
                bus.iBIN   = 20'd111111;
            end else if (c == 6) begin
                bus.iSTART = 1'b0;
                bus.iBIN   = 20'd222;
            end
            if (bus.oDONE !== 1'b1 && bus.oDIG !== digBefore) glitches++;
        end
        exp = sb.pop_front();
        total++;
        if (bus.oDONE !== 1'b1 || c != 22 || bus.oDIG !== exp[31:0] || bus.oOVF !== exp[32]) begin
            bad++;
            $display("FAIL ignore_result done=%b at=%0d dig=%h ovf=%b want done=1 at=22 dig=%h ovf=%b",
                     bus.oDONE, c, bus.oDIG, bus.oOVF, exp[31:0], exp[32]);
        end
        total++;
        if (glitches != 0) begin
            bad++;
            $display("FAIL ignore_hold dig_changes=%0d want 0", glitches);
        end
        repeat (30) begin
            @(negedge clk);
            if (bus.oDONE === 1'b1 || bus.oBUSY === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL ignore_extra activity_cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int doneAt[$];
        int busyErr;
        logic [32:0] exp;
        busyErr = 0;
        @(negedge clk);
        bus.iBIN   = 20'd100;
        bus.iSTART = 1'b1;
        sb.push_back(model(100));
        sb.push_back(model(200));
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bus.iBIN = 20'd200;
            if (i >= 2 && i <= 43 && bus.oBUSY !== !bus.oDONE) busyErr++;
            if (bus.oDONE === 1'b1) begin
                doneAt.push_back(i);
                exp = sb.pop_front();
                total++;
                if (bus.oDIG !== exp[31:0] || bus.oOVF !== exp[32]) begin
                    bad++;
                    $display("FAIL b2b_result n=%0d dig=%h ovf=%b want dig=%h ovf=%b",
                             doneAt.size(), bus.oDIG, bus.oOVF, exp[31:0], exp[32]);
                end
                bus.iSTART = 1'b0;
            end
        end
        total++;
        if (doneAt.size() != 2 || doneAt[0] != 22 || doneAt[1] != 43) begin
            bad++;
            $display("FAIL b2b_timing dones=%0d first=%0d second=%0d want 2 22 43", doneAt.size(),
                     (doneAt.size() > 0) ? doneAt[0] : -1, (doneAt.size() > 1) ? doneAt[1] : -1);
        end
        total++;
        if (busyErr != 0) begin
            bad++;
            $display("FAIL b2b_busy busy_vs_done_errors=%0d want 0", busyErr);
        end
    endtask

    task automatic test_reset_abort();
        int extra;
        extra = 0;
        test_values("pre_abort", 777, 5, 10);
        @(negedge clk);
        bus.iBIN   = 20'd888;
        bus.iSTART = 1'b1;
        @(negedge clk);
        bus.iSTART = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.oDIG !== 32'h0 || bus.oOVF !== 1'b0 || bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs dig=%h ovf=%b busy=%b done=%b want 0 0 0 0",
                     bus.oDIG, bus.oOVF, bus.oBUSY, bus.oDONE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.oDONE === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL abort_done spurious_dones=%0d want 0", extra);
        end
        test_values("post_abort", 314159, 1, 654321);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_values("values", 123456, 999999, 9);
        test_values("overflow", 1000000, 1048575, 42);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover entries=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits. Its output drives the 32-bit digit bus of the six-digit seven-segment display decoder, one nibble per digit, with digit 0 in bits [3:0]. It sits between counters or measurement logic and the display. Each conversion takes one iteration per input bit, with a start/done handshake. The displayed value holds steady during a conversion.

Parameters:
BIN_W, 20, width of binary input; supported range 4..26
DIGITS, 6, number of BCD output digits; supported range 1..8; 4*DIGITS <= 32

Ports:
iCLK  input  1  system clock, rising edge
iRST_N  input  1  asynchronous active-low reset
iSTART  input  1  conversion request, sampled on iCLK
iBIN  input  BIN_W  unsigned binary value, sampled together with iSTART
oBUSY  output  1  high while a conversion is in progress
oDONE  output  1  one-cycle pulse when oDIG/oOVF update
oOVF  output  1  last converted value exceeded 10^DIGITS-1; held until the next update
oDIG  output  32  packed BCD result, digit k in [4k+3:4k]; bits above 4*DIGITS are always 0

Behaviour:
- Reset (async assert, sync release): state=IDLE; oBUSY=0, oDONE=0, oOVF=0, oDIG=32'h0 (display shows all zeros); internal registers cleared. Asserting reset mid-conversion aborts the conversion and no oDONE is produced.
- States:
  - IDLE: iSTART=1 latches iBIN into the shift register, clears the BCD scratch register, loads the iteration counter with BIN_W, and goes to SHIFT.
  - SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch, shreg} shifts left by 1 and the counter decrements. When the counter reaches 1 on this cycle's iteration, go to DONE. Exactly BIN_W SHIFT cycles occur.
  - DONE: one cycle. oDONE=1 and oDIG/oOVF take their new values on entry. Then go to IDLE, or go directly to SHIFT with a new latch if iSTART=1 in this cycle (back-to-back).
- The scratch register is sized for the full BIN_W range (ceil(BIN_W*log10(2)) digits, at least DIGITS), so no internal truncation occurs.
- Overflow: if any scratch digit above DIGITS-1 is nonzero, oOVF=1 and oDIG saturates to all-9s in the low DIGITS nibbles (DIGITS=6 gives 32'h00999999). Otherwise oOVF=0 and oDIG is the low DIGITS nibbles of the scratch register.
- Latency: iSTART sampled at edge N gives oDONE high and updated oDIG/oOVF after edge N+BIN_W+1 (default: 21 clocks).
- oBUSY=1 in SHIFT only (edges N+1..N+BIN_W). It is 0 in IDLE and DONE.
- iSTART while in SHIFT is ignored; no queueing.
- iBIN is only sampled at the accepting edge. Changes to iBIN during a conversion have no effect.
- oDIG and oOVF change only on entry to DONE and on reset. They are never glitched during SHIFT.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then pulse iSTART with iBIN=0 -> after 21 clocks oDONE pulses for 1 cycle, oDIG=32'h00000000, oOVF=0, oBUSY high for exactly 20 cycles.
- iBIN=123456 -> oDIG=32'h00123456, oOVF=0. Then iBIN=999999 -> oDIG=32'h00999999, oOVF=0. Then iBIN=9 -> oDIG=32'h00000009.
- iBIN=1000000, and separately iBIN=20'hFFFFF (1048575) -> oOVF=1, oDIG=32'h00999999. A following conversion of 42 -> oOVF=0, oDIG=32'h00000042.
- Start with 555555, then pulse iSTART with 111111 at cycle 5 of SHIFT and change iBIN mid-run -> single oDONE at clock 21, oDIG=32'h00555555, second request not performed.
- Hold iSTART high continuously with iBIN=100 then 200, changed at the DONE cycle -> back-to-back conversions, oDONE every 21 clocks, results 32'h00000100 then 32'h00000200, oBUSY low only during DONE cycles.
- Complete a conversion of 777, start another, then assert iRST_N=0 at SHIFT cycle 10 -> outputs immediately 0 (oDIG=0), no oDONE. After release, IDLE accepts a new start and 314159 -> oDIG=32'h00314159.
